// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer
// Description : Circular in-order retirement queue for the Tomasulo core.
//               Entries are allocated at issue, filled from the CDB, and
//               retired in program order, at most one per cycle. A retiring
//               mispredicted branch raises a flush and redirects the PC.
//               The decoder reads results for operand forwarding by ROB id.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ROB_W          log2 of entry count (DEPTH = 1 << ROB_W)
// Ports
//   clk, rst       clock, synchronous active-high reset
//   rdy            global enable; low freezes all state and registered outputs
//   issue_*        allocation request from the decoder; issue_rob_id is the
//                  id granted (current tail), rob_full blocks allocation
//   cdb_*          result broadcast (value, branch outcome, taken target)
//   q1_*, q2_*     operand queries: ready/value of entry qN_rob_id
//   commit_*       registered retire pulse with rd / value / id
//   store_commit   registered pulse when the retired entry is a STORE
//   rollback(_pc)  registered flush pulse and redirect PC
// Build option
//   ROB_CDB_BYPASS_EN  when defined, queries also see the CDB broadcast of
//                      the current cycle (same-cycle forwarding)
// ============================================================================
module reorder_buffer #(
    parameter int ROB_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             issue_valid,
    input  logic [1:0]       issue_type,
    input  logic [4:0]       issue_rd,
    input  logic [31:0]      issue_pc,
    input  logic             issue_pred,
    output logic [ROB_W-1:0] issue_rob_id,
    output logic             rob_full,
    input  logic             cdb_valid,
    input  logic [ROB_W-1:0] cdb_rob_id,
    input  logic [31:0]      cdb_value,
    input  logic             cdb_taken,
    input  logic [31:0]      cdb_target,
    input  logic [ROB_W-1:0] q1_rob_id,
    output logic             q1_ready,
    output logic [31:0]      q1_value,
    input  logic [ROB_W-1:0] q2_rob_id,
    output logic             q2_ready,
    output logic [31:0]      q2_value,
    output logic             commit_config,
    output logic [4:0]       commit_rd,
    output logic [31:0]      commit_val,
    output logic [ROB_W-1:0] commit_rob_id,
    output logic             store_commit,
    output logic             rollback,
    output logic [31:0]      rollback_pc
);

    localparam int         c_DEPTH       = 1 << ROB_W;
    localparam logic [1:0] c_TYPE_BRANCH = 2'b01;
    localparam logic [1:0] c_TYPE_STORE  = 2'b10;

    // Per-entry state
    logic [c_DEPTH-1:0] r_valid;
    logic [c_DEPTH-1:0] r_ready;
    logic [c_DEPTH-1:0] r_pred;
    logic [c_DEPTH-1:0] r_taken;
    logic [1:0]         r_type   [c_DEPTH];
    logic [4:0]         r_rd     [c_DEPTH];
    logic [31:0]        r_pc     [c_DEPTH];
    logic [31:0]        r_value  [c_DEPTH];
    logic [31:0]        r_target [c_DEPTH];

    logic [ROB_W-1:0] r_head;
    logic [ROB_W-1:0] r_tail;
    logic [ROB_W:0]   r_count;

    logic        w_retire;
    logic        w_head_branch;
    logic        w_head_store;
    logic        w_flush;
    logic        w_issue;
    logic        w_cdb;
    logic [31:0] w_redirect;

    assign issue_rob_id = r_tail;
    // count never exceeds DEPTH, so its MSB alone marks a full queue
    assign rob_full     = r_count[ROB_W];

    assign w_retire      = rdy & r_valid[r_head] & r_ready[r_head];
    assign w_head_branch = (r_type[r_head] == c_TYPE_BRANCH);
    assign w_head_store  = (r_type[r_head] == c_TYPE_STORE);
    assign w_flush       = w_retire & w_head_branch & (r_taken[r_head] != r_pred[r_head]);
    // A flush this edge wipes the queue, so concurrent issue/CDB are dropped;
    // issue is also blocked during the registered rollback cycle.
    assign w_issue       = rdy & issue_valid & ~rob_full & ~rollback & ~w_flush;
    assign w_cdb         = rdy & cdb_valid & r_valid[cdb_rob_id] & ~w_flush;
    assign w_redirect    = r_taken[r_head] ? r_target[r_head] : (r_pc[r_head] + 32'd4);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid       <= '0;
            r_ready       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            commit_config <= 1'b0;
            commit_rd     <= '0;
            commit_val    <= '0;
            commit_rob_id <= '0;
            store_commit  <= 1'b0;
            rollback      <= 1'b0;
            rollback_pc   <= '0;
        end else if (rdy) begin
            commit_config <= w_retire;
            store_commit  <= w_retire & w_head_store;
            rollback      <= w_flush;
            if (w_retire) begin
                commit_rd     <= w_head_store ? 5'd0 : r_rd[r_head];
                commit_val    <= r_value[r_head];
                commit_rob_id <= r_head;
            end
            if (w_flush) begin
                rollback_pc <= w_redirect;
                r_valid     <= '0;
                r_ready     <= '0;
                r_head      <= '0;
                r_tail      <= '0;
                r_count     <= '0;
            end else begin
                if (w_cdb) begin
                    r_ready[cdb_rob_id]  <= 1'b1;
                    r_value[cdb_rob_id]  <= cdb_value;
                    r_taken[cdb_rob_id]  <= cdb_taken;
                    r_target[cdb_rob_id] <= cdb_target;
                end
                if (w_issue) begin
                    r_valid[r_tail] <= 1'b1;
                    r_ready[r_tail] <= 1'b0;
                    r_type[r_tail]  <= issue_type;
                    r_rd[r_tail]    <= issue_rd;
                    r_pc[r_tail]    <= issue_pc;
                    r_pred[r_tail]  <= issue_pred;
                    r_tail          <= r_tail + 1'b1;
                end
                // Retire clears last so it wins over a CDB write to the head
                if (w_retire) begin
                    r_valid[r_head] <= 1'b0;
                    r_ready[r_head] <= 1'b0;
                    r_head          <= r_head + 1'b1;
                end
                case ({w_issue, w_retire})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Operand queries; value reads as zero until the entry holds its result
    always_comb begin
        q1_ready = r_valid[q1_rob_id] & r_ready[q1_rob_id];
        q1_value = q1_ready ? r_value[q1_rob_id] : 32'd0;
        q2_ready = r_valid[q2_rob_id] & r_ready[q2_rob_id];
        q2_value = q2_ready ? r_value[q2_rob_id] : 32'd0;
`ifdef ROB_CDB_BYPASS_EN
        if (cdb_valid && (cdb_rob_id == q1_rob_id) && r_valid[q1_rob_id]) begin
            q1_ready = 1'b1;
            q1_value = cdb_value;
        end
        if (cdb_valid && (cdb_rob_id == q2_rob_id) && r_valid[q2_rob_id]) begin
            q2_ready = 1'b1;
            q2_value = cdb_value;
        end
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reorder_buffer
// Description : Directed self-checking bench for reorder_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        issue_valid, issue_pred;
    logic [1:0]  issue_type;
    logic [4:0]  issue_rd;
    logic [31:0] issue_pc;
    logic [3:0]  issue_rob_id;
    logic        rob_full;
    logic        cdb_valid, cdb_taken;
    logic [3:0]  cdb_rob_id;
    logic [31:0] cdb_value, cdb_target;
    logic [3:0]  q1_rob_id, q2_rob_id;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_value, q2_value;
    logic        commit_config, store_commit, rollback;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val, rollback_pc;
    logic [3:0]  commit_rob_id;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reorder_buffer #(.ROB_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_pc(issue_pc), .issue_pred(issue_pred), .issue_rob_id(issue_rob_id),
        .rob_full(rob_full),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
        .cdb_taken(cdb_taken), .cdb_target(cdb_target),
        .q1_rob_id(q1_rob_id), .q1_ready(q1_ready), .q1_value(q1_value),
        .q2_rob_id(q2_rob_id), .q2_ready(q2_ready), .q2_value(q2_value),
        .commit_config(commit_config), .commit_rd(commit_rd), .commit_val(commit_val),
        .commit_rob_id(commit_rob_id), .store_commit(store_commit),
        .rollback(rollback), .rollback_pc(rollback_pc)
    );

    // Advance one clock; outputs are then sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_type = 0; issue_rd = 0; issue_pc = 0; issue_pred = 0;
        cdb_valid = 0; cdb_rob_id = 0; cdb_value = 0; cdb_taken = 0; cdb_target = 0;
        q1_rob_id = 0; q2_rob_id = 0;
    endtask

    task automatic do_reset();
        rst = 1; step(); step(); rst = 0;
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc, input logic pred);
        issue_valid = 1; issue_type = t; issue_rd = rd; issue_pc = pc; issue_pred = pred;
        step();
        issue_valid = 0;
    endtask

    task automatic cdb(input logic [3:0] id, input logic [31:0] val, input logic tk, input logic [31:0] tgt);
        cdb_valid = 1; cdb_rob_id = id; cdb_value = val; cdb_taken = tk; cdb_target = tgt;
        step();
        cdb_valid = 0;
    endtask

    task automatic test_reset();
        issue(2'b00, 5'd4, 32'h10, 1'b0);
        cdb(4'd0, 32'h5A, 1'b0, 32'h0);
        step();
        n_cmp++; if (commit_val !== 32'h5A) begin n_fail++; $display("FAIL rst_pre_val got=%h exp=%h", commit_val, 32'h5A); end
        // reset must win even with rdy low
        rdy = 0; issue(2'b00, 5'd1, 32'h0, 1'b0); do_reset(); rdy = 1;
        n_cmp++; if (issue_rob_id !== 4'd0) begin n_fail++; $display("FAIL rst_tail got=%0d exp=0", issue_rob_id); end
        n_cmp++; if (rob_full !== 1'b0) begin n_fail++; $display("FAIL rst_full got=%b exp=0", rob_full); end
        n_cmp++; if (commit_config !== 1'b0) begin n_fail++; $display("FAIL rst_cc got=%b exp=0", commit_config); end
        n_cmp++; if (commit_val !== 32'h0) begin n_fail++; $display("FAIL rst_val got=%h exp=0", commit_val); end
        n_cmp++; if (commit_rd !== 5'd0) begin n_fail++; $display("FAIL rst_rd got=%0d exp=0", commit_rd); end
        n_cmp++; if (rollback !== 1'b0 || store_commit !== 1'b0) begin n_fail++; $display("FAIL rst_pulses got=%b%b exp=00", rollback, store_commit); end
        n_cmp++; if (rollback_pc !== 32'h0) begin n_fail++; $display("FAIL rst_rbpc got=%h exp=0", rollback_pc); end
        n_cmp++; if (q1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_q1 got=%b exp=0", q1_ready); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (issue_rob_id !== 4'(i)) begin n_fail++; $display("FAIL fill_id%0d got=%0d exp=%0d", i, issue_rob_id, i); end
            n_cmp++; if (rob_full !== 1'b0) begin n_fail++; $display("FAIL fill_notfull%0d got=%b exp=0", i, rob_full); end
            issue(2'b00, 5'(i), 32'(i * 4), 1'b0);
        end
        n_cmp++; if (rob_full !== 1'b1) begin n_fail++; $display("FAIL fill_full got=%b exp=1", rob_full); end
        issue(2'b00, 5'd31, 32'h0, 1'b0);
        n_cmp++; if (issue_rob_id !== 4'd0) begin n_fail++; $display("FAIL fill_17th_tail got=%0d exp=0", issue_rob_id); end
        n_cmp++; if (rob_full !== 1'b1) begin n_fail++; $display("FAIL fill_17th_full got=%b exp=1", rob_full); end
        q1_rob_id = 4'd15; #1;
        n_cmp++; if (q1_ready !== 1'b0 || q1_value !== 32'h0) begin n_fail++; $display("FAIL fill_q1 got=%b/%h exp=0/0", q1_ready, q1_value); end
        q1_rob_id = 4'd0;
    endtask

    task automatic test_out_of_order();
        do_reset();
        issue(2'b00, 5'd1, 32'h0, 1'b0);
        issue(2'b00, 5'd2, 32'h4, 1'b0);
        issue(2'b00, 5'd3, 32'h8, 1'b0);
        cdb_valid = 1; cdb_rob_id = 4'd2; cdb_value = 32'h30; step();
        n_cmp++; if (commit_config !== 1'b0) begin n_fail++; $display("FAIL ooo_nocommit got=%b exp=0", commit_config); end
        q1_rob_id = 4'd2; q2_rob_id = 4'd0; #1;
        n_cmp++; if (q1_ready !== 1'b1 || q1_value !== 32'h30) begin n_fail++; $display("FAIL ooo_q1 got=%b/%h exp=1/30", q1_ready, q1_value); end
        n_cmp++; if (q2_ready !== 1'b0 || q2_value !== 32'h0) begin n_fail++; $display("FAIL ooo_q2 got=%b/%h exp=0/0", q2_ready, q2_value); end
        cdb_rob_id = 4'd0; cdb_value = 32'h10; step();
        n_cmp++; if (commit_config !== 1'b0) begin n_fail++; $display("FAIL ooo_latency got=%b exp=0", commit_config); end
        cdb_rob_id = 4'd1; cdb_value = 32'h20; step();
        cdb_valid = 0;
        n_cmp++; if (commit_config !== 1'b1 || commit_rob_id !== 4'd0 || commit_val !== 32'h10 || commit_rd !== 5'd1)
            begin n_fail++; $display("FAIL ooo_c0 got=%b/%0d/%h/%0d exp=1/0/10/1", commit_config, commit_rob_id, commit_val, commit_rd); end
        step();
        n_cmp++; if (commit_config !== 1'b1 || commit_rob_id !== 4'd1 || commit_val !== 32'h20 || commit_rd !== 5'd2)
            begin n_fail++; $display("FAIL ooo_c1 got=%b/%0d/%h/%0d exp=1/1/20/2", commit_config, commit_rob_id, commit_val, commit_rd); end
        step();
        n_cmp++; if (commit_config !== 1'b1 || commit_rob_id !== 4'd2 || commit_val !== 32'h30 || commit_rd !== 5'd3)
            begin n_fail++; $display("FAIL ooo_c2 got=%b/%0d/%h/%0d exp=1/2/30/3", commit_config, commit_rob_id, commit_val, commit_rd); end
        step();
        n_cmp++; if (commit_config !== 1'b0) begin n_fail++; $display("FAIL ooo_end got=%b exp=0", commit_config); end
        q1_rob_id = 0; q2_rob_id = 0;
    endtask

    task automatic test_mispredict();
        do_reset();
        issue(2'b01, 5'd1, 32'h100, 1'b0);
        issue(2'b00, 5'd2, 32'h104, 1'b0);
        issue(2'b00, 5'd3, 32'h108, 1'b0);
        issue(2'b00, 5'd4, 32'h10C, 1'b0);
        cdb(4'd0, 32'h104, 1'b1, 32'h200);
        // Issue and CDB in the flush cycle must be discarded
        issue_valid = 1; issue_type = 2'b00; issue_rd = 5'd9;
        cdb_valid = 1; cdb_rob_id = 4'd1; cdb_value = 32'h99;
        step();
        cdb_valid = 0; q1_rob_id = 4'd1; #1;
        n_cmp++; if (commit_config !== 1'b1 || rollback !== 1'b1) begin n_fail++; $display("FAIL mp_pulses got=%b%b exp=11", commit_config, rollback); end
        n_cmp++; if (rollback_pc !== 32'h200) begin n_fail++; $display("FAIL mp_pc got=%h exp=200", rollback_pc); end
        n_cmp++; if (commit_rd !== 5'd1 || commit_val !== 32'h104) begin n_fail++; $display("FAIL mp_commit got=%0d/%h exp=1/104", commit_rd, commit_val); end
        n_cmp++; if (issue_rob_id !== 4'd0 || rob_full !== 1'b0) begin n_fail++; $display("FAIL mp_empty got=%0d/%b exp=0/0", issue_rob_id, rob_full); end
        n_cmp++; if (q1_ready !== 1'b0) begin n_fail++; $display("FAIL mp_q1 got=%b exp=0", q1_ready); end
        step();
        n_cmp++; if (rollback !== 1'b0 || commit_config !== 1'b0) begin n_fail++; $display("FAIL mp_after got=%b%b exp=00", rollback, commit_config); end
        n_cmp++; if (issue_rob_id !== 4'd0) begin n_fail++; $display("FAIL mp_rbissue got=%0d exp=0", issue_rob_id); end
        step();
        issue_valid = 0;
        n_cmp++; if (issue_rob_id !== 4'd1) begin n_fail++; $display("FAIL mp_resume got=%0d exp=1", issue_rob_id); end
        q1_rob_id = 0;
    endtask

    task automatic test_branch_variants();
        do_reset();
        issue(2'b01, 5'd5, 32'h300, 1'b1);
        issue(2'b01, 5'd0, 32'h1000, 1'b1);
        cdb(4'd0, 32'h304, 1'b1, 32'h400);
        cdb(4'd1, 32'h0, 1'b0, 32'h500);
        n_cmp++; if (commit_config !== 1'b1 || commit_rd !== 5'd5 || commit_val !== 32'h304 || rollback !== 1'b0)
            begin n_fail++; $display("FAIL br_ok got=%b/%0d/%h/%b exp=1/5/304/0", commit_config, commit_rd, commit_val, rollback); end
        step();
        n_cmp++; if (rollback !== 1'b1 || rollback_pc !== 32'h1004) begin n_fail++; $display("FAIL br_nt got=%b/%h exp=1/1004", rollback, rollback_pc); end
    endtask

    task automatic test_full_retire_issue();
        do_reset();
        for (int i = 0; i < 16; i++) issue(2'b00, 5'(i), 32'h0, 1'b0);
        cdb(4'd0, 32'hA0, 1'b0, 32'h0);
        issue_valid = 1; issue_type = 2'b00; issue_rd = 5'd20;
        step();
        n_cmp++; if (commit_config !== 1'b1 || commit_rob_id !== 4'd0 || commit_val !== 32'hA0)
            begin n_fail++; $display("FAIL full_retire got=%b/%0d/%h exp=1/0/a0", commit_config, commit_rob_id, commit_val); end
        n_cmp++; if (rob_full !== 1'b0 || issue_rob_id !== 4'd0) begin n_fail++; $display("FAIL full_noissue got=%b/%0d exp=0/0", rob_full, issue_rob_id); end
        step();
        issue_valid = 0;
        n_cmp++; if (rob_full !== 1'b1 || issue_rob_id !== 4'd1 || commit_config !== 1'b0)
            begin n_fail++; $display("FAIL full_reissue got=%b/%0d/%b exp=1/1/0", rob_full, issue_rob_id, commit_config); end
    endtask

    task automatic test_store();
        do_reset();
        issue(2'b10, 5'd7, 32'h40, 1'b0);
        issue(2'b11, 5'd9, 32'h44, 1'b0);
        cdb(4'd0, 32'h55, 1'b0, 32'h0);
        cdb(4'd1, 32'h66, 1'b0, 32'h0);
        n_cmp++; if (store_commit !== 1'b1 || commit_config !== 1'b1 || commit_rd !== 5'd0 || commit_val !== 32'h55)
            begin n_fail++; $display("FAIL st_commit got=%b/%b/%0d/%h exp=1/1/0/55", store_commit, commit_config, commit_rd, commit_val); end
        step();
        n_cmp++; if (store_commit !== 1'b0 || commit_rd !== 5'd9 || commit_val !== 32'h66)
            begin n_fail++; $display("FAIL st_type3 got=%b/%0d/%h exp=0/9/66", store_commit, commit_rd, commit_val); end
        step();
        n_cmp++; if (commit_config !== 1'b0 || store_commit !== 1'b0) begin n_fail++; $display("FAIL st_end got=%b%b exp=00", commit_config, store_commit); end
    endtask

    task automatic test_bypass();
        do_reset();
        for (int i = 0; i < 6; i++) issue(2'b00, 5'd1, 32'h0, 1'b0);
        q1_rob_id = 4'd5; cdb_valid = 1; cdb_rob_id = 4'd5; cdb_value = 32'hABCD; #1;
`ifdef ROB_CDB_BYPASS_EN
        n_cmp++; if (q1_ready !== 1'b1 || q1_value !== 32'hABCD) begin n_fail++; $display("FAIL byp_same got=%b/%h exp=1/abcd", q1_ready, q1_value); end
`else
        n_cmp++; if (q1_ready !== 1'b0 || q1_value !== 32'h0) begin n_fail++; $display("FAIL byp_same got=%b/%h exp=0/0", q1_ready, q1_value); end
`endif
        step();
        cdb_valid = 0; #1;
        n_cmp++; if (q1_ready !== 1'b1 || q1_value !== 32'hABCD) begin n_fail++; $display("FAIL byp_next got=%b/%h exp=1/abcd", q1_ready, q1_value); end
        // CDB aimed at an unallocated entry leaves it untouched
        q2_rob_id = 4'd10; cdb(4'd10, 32'h77, 1'b0, 32'h0);
        n_cmp++; if (q2_ready !== 1'b0 || q2_value !== 32'h0) begin n_fail++; $display("FAIL byp_invalid got=%b/%h exp=0/0", q2_ready, q2_value); end
        q1_rob_id = 0; q2_rob_id = 0;
    endtask

    task automatic test_rdy_hold();
        do_reset();
        issue(2'b00, 5'd3, 32'h0, 1'b0);
        cdb(4'd0, 32'h77, 1'b0, 32'h0);
        rdy = 0; issue_valid = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (commit_config !== 1'b0 || issue_rob_id !== 4'd1) begin n_fail++; $display("FAIL rdy_freeze%0d got=%b/%0d exp=0/1", i, commit_config, issue_rob_id); end
        end
        rdy = 1; issue_valid = 0; step();
        n_cmp++; if (commit_config !== 1'b1 || commit_val !== 32'h77) begin n_fail++; $display("FAIL rdy_resume got=%b/%h exp=1/77", commit_config, commit_val); end
        rdy = 0; step(); step();
        n_cmp++; if (commit_config !== 1'b1 || commit_rd !== 5'd3) begin n_fail++; $display("FAIL rdy_hold got=%b/%0d exp=1/3", commit_config, commit_rd); end
        rdy = 1; step();
        n_cmp++; if (commit_config !== 1'b0) begin n_fail++; $display("FAIL rdy_drop got=%b exp=0", commit_config); end
    endtask

    initial begin
        rst = 1; rdy = 1;
        idle_inputs();
        do_reset();
        test_reset();
        test_fill();
        test_out_of_order();
        test_mispredict();
        test_branch_variants();
        test_full_retire_issue();
        test_store();
        test_bypass();
        test_rdy_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
